time_decoder_seq: RTL and testbench

- Sequential, parametrised successor to the stopwatch's combinational time decoder.
- Converts a binary tick count into eight BCD display digits: centiseconds, seconds, minutes and hours, two digits each.
- Uses one shared restoring divider over a fixed divisor schedule instead of a chain of wide combinational dividers.
- Adds a start/busy/done handshake, a 24-hour/100-hour mode and a day-overflow flag. Sits between the stopwatch counter and the 7-segment display driver.

---
 rtl/time_decoder_seq_if.sv | 23 ++
 rtl/time_decoder_seq.sv | 146 ++++++++++++++
 tb/tb_time_decoder_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/time_decoder_seq_if.sv
// Handshake and display bus between the stopwatch counter (master) and the
// sequential time decoder (slave).
interface time_decoder_seq_if #(
  parameter int unsigned CNT_W = 64
) ();
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic             mode24;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [3:0]       cs0, cs1, s0, s1, m0, m1, h0, h1;

  modport master (
    output start, cnt, mode24,
    input  busy, done, ovf, cs0, cs1, s0, s1, m0, m1, h0, h1
  );

  modport slave (
    input  start, cnt, mode24,
    output busy, done, ovf, cs0, cs1, s0, s1, m0, m1, h0, h1
  );
endinterface

// File: rtl/time_decoder_seq.sv
// Sequential tick-count to BCD time decoder: one shared restoring divider
// walks a fixed divisor schedule, then publishes all digits at once.
module time_decoder_seq #(
  parameter int unsigned     CNT_W        = 64,
  parameter longint unsigned TICKS_PER_CS = 64'd100000
) (
  input logic               clk,
  input logic               rst_n,
  time_decoder_seq_if.slave bus
);
  localparam int unsigned     BIT_W    = $clog2(CNT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CNT_W - 1);

  if (CNT_W < 8 || CNT_W > 64) begin : g_bad_cnt_w
    $error("time_decoder_seq: CNT_W must be within 8..64");
  end
  if (TICKS_PER_CS < 64'd1 ||
      (CNT_W < 64 && (TICKS_PER_CS >> CNT_W) != 64'd0)) begin : g_bad_tpc
    $error("time_decoder_seq: TICKS_PER_CS must be >= 1 and fit in CNT_W bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_STORE} state_t;

  state_t           state_q;
  logic [3:0]       k_q;
  logic [BIT_W-1:0] bit_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] quo_q;
  logic             mode24_q;
  logic             ovf_sh_q;
  logic [3:0]       shadow_q [8];
  logic [3:0]       digit_q  [8];
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  logic [CNT_W-1:0] divisor;
  logic [CNT_W:0]   prem;
  logic             fits;
  logic [CNT_W-1:0] rem_d;
  logic [CNT_W-1:0] quo_d;

  always_comb begin
    divisor = CNT_W'(10);
    case (k_q)
      4'd0:       divisor = CNT_W'(TICKS_PER_CS);
      4'd4, 4'd6: divisor = CNT_W'(6);
      4'd7:       divisor = mode24_q ? CNT_W'(24) : CNT_W'(100);
      default:    divisor = CNT_W'(10);
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    prem  = {rem_q, quo_q[CNT_W-1]};
    fits  = (prem >= {1'b0, divisor});
    rem_d = CNT_W'(fits ? (prem - {1'b0, divisor}) : prem);
    quo_d = {quo_q[CNT_W-2:0], fits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      bit_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      mode24_q <= 1'b0;
      ovf_sh_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= '0;
        digit_q[i]  <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            quo_q    <= bus.cnt;
            mode24_q <= bus.mode24;
            rem_q    <= '0;
            bit_q    <= '0;
            k_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_DIV;
          end
        end
        S_DIV: begin
          if (bit_q == LAST_BIT) begin
            // Step boundary: route the remainder and seed the next dividend.
            bit_q <= '0;
            rem_q <= '0;
            k_q   <= k_q + 4'd1;
            case (k_q)
              4'd7: begin
                quo_q    <= rem_d;
                ovf_sh_q <= (quo_d != '0);
              end
              4'd8: begin
                quo_q       <= quo_d;
                shadow_q[6] <= rem_d[3:0];
                shadow_q[7] <= quo_d[3:0];
                state_q     <= S_STORE;
              end
              default: begin
                quo_q <= quo_d;
                if (k_q != 4'd0) begin
                  shadow_q[3'(k_q - 4'd1)] <= rem_d[3:0];
                end
              end
            endcase
          end else begin
            bit_q <= bit_q + 1'b1;
            rem_q <= rem_d;
            quo_q <= quo_d;
          end
        end
        S_STORE: begin
          for (int i = 0; i < 8; i++) begin
            digit_q[i] <= shadow_q[i];
          end
          ovf_q   <= ovf_sh_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.cs0  = digit_q[0];
  assign bus.cs1  = digit_q[1];
  assign bus.s0   = digit_q[2];
  assign bus.s1   = digit_q[3];
  assign bus.m0   = digit_q[4];
  assign bus.m1   = digit_q[5];
  assign bus.h0   = digit_q[6];
  assign bus.h1   = digit_q[7];
endmodule

// File: tb/tb_time_decoder_seq.sv
// Bench for time_decoder_seq: a 64-bit default instance and a 16-bit,
// one-tick-per-centisecond instance, checked against an arithmetic time model.
module tb_time_decoder_seq;
  logic clk;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;

  time_decoder_seq_if #(.CNT_W(64)) if64 ();
  time_decoder_seq_if #(.CNT_W(16)) if16 ();

  time_decoder_seq #(.CNT_W(64), .TICKS_PER_CS(64'd100000)) dut64 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if64.slave)
  );

  time_decoder_seq #(.CNT_W(16), .TICKS_PER_CS(64'd1)) dut16 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {ovf, h1, h0, m1, m0, s1, s0, cs1, cs0} from plain time arithmetic.
  function automatic logic [32:0] model(input longint unsigned c,
                                        input longint unsigned tpc,
                                        input bit m24);
    longint unsigned cs, hrs, wrap, h;
    cs   = c / tpc;
    hrs  = cs / 360000;
    wrap = m24 ? 24 : 100;
    h    = hrs % wrap;
    return {hrs >= wrap, 4'(h / 10), 4'(h % 10),
            4'((cs / 60000) % 6), 4'((cs / 6000) % 10),
            4'((cs / 1000) % 6), 4'((cs / 100) % 10),
            4'((cs / 10) % 10), 4'(cs % 10)};
  endfunction

  function automatic logic [32:0] resultOf(input bit s);
    if (s) return {if16.ovf, if16.h1, if16.h0, if16.m1, if16.m0,
                   if16.s1, if16.s0, if16.cs1, if16.cs0};
    return {if64.ovf, if64.h1, if64.h0, if64.m1, if64.m0,
            if64.s1, if64.s0, if64.cs1, if64.cs0};
  endfunction

  function automatic logic busyOf(input bit s);
    return s ? if16.busy : if64.busy;
  endfunction

  function automatic logic doneOf(input bit s);
    return s ? if16.done : if64.done;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit s, input logic st, input logic [63:0] c, input logic m24);
    if (s) begin
      if16.start  = st;
      if16.cnt    = c[15:0];
      if16.mode24 = m24;
    end else begin
      if64.start  = st;
      if64.cnt    = c;
      if64.mode24 = m24;
    end
  endtask

  // Full conversion; a one-cycle start with a different cnt is injected
  // at cycle injectAt (negative disables it).
  task automatic runConv(input bit s, input logic [63:0] c, input bit m24,
                         input string tag, input int injectAt);
    int          n;
    int          expLat;
    logic [32:0] exp;
    expLat = s ? 9 * 16 + 1 : 9 * 64 + 1;
    exp    = model(s ? {48'd0, c[15:0]} : c, s ? 64'd1 : 64'd100000, m24);
    applyStimulus(s, 1'b1, c, m24);
    tick();
    applyStimulus(s, 1'b0, ~c, ~m24);
    checkOutput({tag, "_busy_on_accept"}, 64'(busyOf(s)), 64'd1);
    n = 0;
    while (!doneOf(s) && n < expLat + 50) begin
      applyStimulus(s, n == injectAt, c ^ 64'h0000_0123_4567_89AB, ~m24);
      tick();
      n++;
    end
    applyStimulus(s, 1'b0, ~c, ~m24);
    checkOutput({tag, "_latency"}, 64'(n), 64'(expLat));
    checkOutput({tag, "_result"}, 64'(resultOf(s)), 64'(exp));
    checkOutput({tag, "_busy_at_done"}, 64'(busyOf(s)), 64'd0);
    tick();
    checkOutput({tag, "_done_one_cycle"}, 64'(doneOf(s)), 64'd0);
    checkOutput({tag, "_no_restart"}, 64'(busyOf(s)), 64'd0);
  endtask

  initial begin
    int          n;
    int          nDone;
    logic [63:0] rc;
    bit          rm;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'd0, 1'b0);
    tick();
    tick();
    checkOutput("reset64_result", 64'(resultOf(1'b0)), 64'd0);
    checkOutput("reset64_busy", 64'(busyOf(1'b0)), 64'd0);
    checkOutput("reset64_done", 64'(doneOf(1'b0)), 64'd0);
    checkOutput("reset16_result", 64'(resultOf(1'b1)), 64'd0);
    rst_n = 1'b1;
    tick();

    runConv(1'b0, 64'd50256700000, 1'b1, "normal", -1);
    checkOutput("normal_const", 64'(resultOf(1'b0)), 64'h0_0123_4567);
    runConv(1'b0, 64'd900000000000, 1'b1, "wrap24", -1);
    checkOutput("wrap24_const", 64'(resultOf(1'b0)), 64'h1_0100_0000);
    runConv(1'b0, 64'd900000000000, 1'b0, "wrap100", -1);
    checkOutput("wrap100_const", 64'(resultOf(1'b0)), 64'h0_2500_0000);
    runConv(1'b0, 64'd99999, 1'b1, "subcs", -1);
    runConv(1'b0, 64'd50256700000, 1'b1, "start_while_busy", 100);
    runConv(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "all_ones", -1);

    // Reset in the middle of a conversion must abort it silently.
    applyStimulus(1'b0, 1'b1, 64'd987654321098, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 64'd0, 1'b0);
    repeat (299) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midreset_result", 64'(resultOf(1'b0)), 64'd0);
    checkOutput("midreset_busy", 64'(busyOf(1'b0)), 64'd0);
    nDone = 0;
    repeat (700) begin
      tick();
      if (doneOf(1'b0)) nDone++;
    end
    checkOutput("midreset_no_done", 64'(nDone), 64'd0);

    runConv(1'b1, 64'h0000_0000_0000_FFFF, 1'b0, "w16_ffff", -1);
    checkOutput("w16_ffff_const", 64'(resultOf(1'b1)), 64'h0_0010_5535);

    // Back-to-back with start held high; the done cycle is the only idle cycle.
    applyStimulus(1'b0, 1'b1, 64'd123456789012, 1'b1);
    tick();
    checkOutput("b2b_first_busy", 64'(busyOf(1'b0)), 64'd1);
    if64.cnt    = 64'd777777777777;
    if64.mode24 = 1'b0;
    n = 0;
    while (!doneOf(1'b0) && n < 700) begin
      tick();
      n++;
    end
    checkOutput("b2b_first_latency", 64'(n), 64'(9 * 64 + 1));
    checkOutput("b2b_first_result", 64'(resultOf(1'b0)), 64'(model(64'd123456789012, 64'd100000, 1'b1)));
    checkOutput("b2b_idle_gap", 64'(busyOf(1'b0)), 64'd0);
    tick();
    checkOutput("b2b_reaccept_busy", 64'(busyOf(1'b0)), 64'd1);
    checkOutput("b2b_reaccept_done", 64'(doneOf(1'b0)), 64'd0);
    if64.start = 1'b0;
    n = 0;
    while (!doneOf(1'b0) && n < 700) begin
      tick();
      n++;
    end
    checkOutput("b2b_second_latency", 64'(n), 64'(9 * 64 + 1));
    checkOutput("b2b_second_result", 64'(resultOf(1'b0)), 64'(model(64'd777777777777, 64'd100000, 1'b0)));
    tick();

    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) rc = {$urandom, $urandom};
      else rc = 64'($urandom) << $urandom_range(0, 20);
      rm = 1'($urandom_range(0, 1));
      runConv(1'b0, rc, rm, $sformatf("rand64_%0d", i), -1);
    end
    for (int i = 0; i < 4; i++) begin
      rc = 64'($urandom_range(0, 65535));
      rm = 1'($urandom_range(0, 1));
      runConv(1'b1, rc, rm, $sformatf("rand16_%0d", i), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
